// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one aligned doubleword fetch per PC,
// and presents the selected 32-bit instruction to IF/ID once the response arrives.
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_stall,
  input  logic        control_transfer_i,
  input  logic [63:0] control_target_pc_i,
  input  logic        exception_transfer_i,
  input  logic [63:0] exception_target_pc_i,
  output logic        if_stall_req,
  output logic        if_req_valid,
  output logic [63:0] if_req_addr,
  input  logic        if_req_ready,
  input  logic        if_resp_valid,
  input  logic [63:0] if_resp_data,
  input  logic        if_resp_err,
  output logic [63:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_inst_valid_o,
  output logic        if_misalign_o,
  output logic        if_access_fault_o
);

  localparam logic [1:0] STALL_NEXT = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        misalign_q, misalign_d;
  logic        fault_q, fault_d;
  logic [63:0] next_pc;
  logic        pc_misaligned;

  assign pc_misaligned = (pc_q[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      misalign_q <= misalign_d;
      fault_q    <= fault_d;
    end
  end

  // Exception redirect outranks a branch/jump redirect.
  always_comb begin
    if (exception_transfer_i) begin
      next_pc = exception_target_pc_i;
    end else if (control_transfer_i) begin
      next_pc = control_target_pc_i;
    end else begin
      next_pc = pc_q + 64'd4;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    misalign_d = misalign_q;
    fault_d    = fault_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (pc_misaligned) begin
          state_d    = S_DONE;
          misalign_d = 1'b1;
          inst_d     = NOP_INST;
        end else if (if_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (if_resp_valid) begin
          state_d = S_DONE;
          fault_d = if_resp_err;
          if (if_resp_err) begin
            inst_d = NOP_INST;
          end else if (pc_q[2]) begin
            inst_d = if_resp_data[63:32];
          end else begin
            inst_d = if_resp_data[31:0];
          end
        end
      end
      S_DONE: begin
        if (pc_stall == STALL_NEXT) begin
          state_d    = S_REQ;
          pc_d       = next_pc;
          inst_d     = NOP_INST;
          misalign_d = 1'b0;
          fault_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if_stall_req      = (state_q != S_DONE);
    if_req_valid      = (state_q == S_REQ) && !pc_misaligned;
    if_req_addr       = {pc_q[63:3], 3'b000};
    if_pc_o           = pc_q;
    if_inst_o         = (state_q == S_DONE) ? inst_q : NOP_INST;
    if_inst_valid_o   = (state_q == S_DONE) && !misalign_q && !fault_q;
    if_misalign_o     = misalign_q;
    if_access_fault_o = fault_q;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized redirects,
// bus delays and errors checked against a PC/memory model kept in the bench.
module tb_if_fetch_unit;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [1:0]  NEXT   = 2'b00;
  localparam logic [1:0]  KEEP   = 2'b01;

  logic        clk, rst;
  logic [1:0]  pc_stall;
  logic        control_transfer_i, exception_transfer_i;
  logic [63:0] control_target_pc_i, exception_target_pc_i;
  logic        if_stall_req, if_req_valid, if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid, if_resp_err;
  logic [63:0] if_resp_data;
  logic [63:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_inst_valid_o, if_misalign_o, if_access_fault_o;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] mpc;
  logic [31:0] salt;

  if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc_stall(pc_stall),
    .control_transfer_i(control_transfer_i), .control_target_pc_i(control_target_pc_i),
    .exception_transfer_i(exception_transfer_i), .exception_target_pc_i(exception_target_pc_i),
    .if_stall_req(if_stall_req), .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .if_req_ready(if_req_ready), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .if_resp_err(if_resp_err), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
    .if_inst_valid_o(if_inst_valid_o), .if_misalign_o(if_misalign_o),
    .if_access_fault_o(if_access_fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: every aligned doubleword holds a value derived from its address.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ a[63:32] ^ salt, (a[31:0] * 32'h0100_0193) ^ ~salt};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] pc, input bit err);
    logic [63:0] w;
    if (err) return NOP;
    w = mem_word({pc[63:3], 3'b000}) >> (32 * int'(pc[2]));
    return w[31:0];
  endfunction

  function automatic logic [63:0] aligned(input logic [63:0] pc);
    return {pc[63:3], 3'b000};
  endfunction

  // Accept one request after rdy cycles, respond rsp cycles later. Call at posedge+1.
  task automatic serve(input int rdy, input int rsp, input bit err, output logic [63:0] addr);
    int cyc = 0;
    bit acc = 0;
    addr = '0;
    while (!acc && cyc < 40) begin
      if_req_ready = (cyc >= rdy);
      @(negedge clk);
      if (if_req_valid && if_req_ready) begin
        acc = 1;
        addr = if_req_addr;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if_req_ready = 1'b0;
    checks++;
    if (!acc) begin failures++; $display("FAIL req_accept timeout got=0 exp=1"); end
    repeat (rsp) begin @(posedge clk); #1; end
    if_resp_valid = 1'b1;
    if_resp_data  = mem_word(addr);
    if_resp_err   = err;
    @(posedge clk); #1;
    if_resp_valid = 1'b0;
    if_resp_err   = 1'b0;
    if_resp_data  = {$urandom, $urandom};
  endtask

  // Pulse STALL_NEXT for one edge in DONE, updating the model PC by the redirect rules.
  task automatic advance(input bit ctl, input logic [63:0] ct, input bit exc, input logic [63:0] et);
    pc_stall = NEXT;
    control_transfer_i = ctl; control_target_pc_i = ct;
    exception_transfer_i = exc; exception_target_pc_i = et;
    @(posedge clk); #1;
    pc_stall = KEEP;
    control_transfer_i = 1'b0; exception_transfer_i = 1'b0;
    mpc = exc ? et : (ctl ? ct : mpc + 64'd4);
  endtask

  task automatic test_reset();
    #12;
    checks += 7;
    if (if_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", if_req_valid); end
    if (if_stall_req !== 1'b1) begin failures++; $display("FAIL rst_stall got=%b exp=1", if_stall_req); end
    if (if_inst_valid_o !== 1'b0) begin failures++; $display("FAIL rst_inst_valid got=%b exp=0", if_inst_valid_o); end
    if (if_inst_o !== NOP) begin failures++; $display("FAIL rst_inst got=%h exp=%h", if_inst_o, NOP); end
    if (if_pc_o !== RST_PC) begin failures++; $display("FAIL rst_pc got=%h exp=%h", if_pc_o, RST_PC); end
    if (if_misalign_o !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%b exp=0", if_misalign_o); end
    if (if_access_fault_o !== 1'b0) begin failures++; $display("FAIL rst_fault got=%b exp=0", if_access_fault_o); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks += 2;
    if (if_req_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid got=%b exp=1", if_req_valid); end
    if (if_req_addr !== RST_PC) begin failures++; $display("FAIL first_req_addr got=%h exp=%h", if_req_addr, RST_PC); end
    mpc = RST_PC;
    @(posedge clk); #1;
  endtask

  task automatic test_sequential();
    logic [63:0] a;
    logic [31:0] e;
    for (int unsigned k = 0; k < 2; k++) begin
      if (k == 1) advance(0, '0, 0, '0);
      serve(0, 0, 0, a);
      @(negedge clk);
      e = exp_inst(mpc, 0);
      checks += 5;
      if (a !== aligned(mpc)) begin failures++; $display("FAIL seq_addr got=%h exp=%h", a, aligned(mpc)); end
      if (if_stall_req !== 1'b0) begin failures++; $display("FAIL seq_stall got=%b exp=0", if_stall_req); end
      if (if_inst_o !== e) begin failures++; $display("FAIL seq_inst got=%h exp=%h", if_inst_o, e); end
      if (if_inst_valid_o !== 1'b1) begin failures++; $display("FAIL seq_inst_valid got=%b exp=1", if_inst_valid_o); end
      if (if_pc_o !== mpc) begin failures++; $display("FAIL seq_pc got=%h exp=%h", if_pc_o, mpc); end
    end
    pc_stall = 2'b10; control_transfer_i = 1'b1; control_target_pc_i = 64'h1234_5678;
    repeat (2) begin @(posedge clk); #1; end
    pc_stall = KEEP; control_transfer_i = 1'b0;
    @(negedge clk);
    checks += 2;
    if (if_pc_o !== mpc) begin failures++; $display("FAIL hold_pc got=%h exp=%h", if_pc_o, mpc); end
    if (if_inst_o !== e) begin failures++; $display("FAIL hold_inst got=%h exp=%h", if_inst_o, e); end
  endtask

  task automatic test_ready_stall();
    logic [31:0] e;
    advance(0, '0, 0, '0);
    for (int unsigned i = 0; i < 4; i++) begin
      if_req_ready = (i == 3);
      @(negedge clk);
      checks += 3;
      if (if_req_valid !== 1'b1) begin failures++; $display("FAIL stall_req_valid c%0d got=%b exp=1", i, if_req_valid); end
      if (if_req_addr !== aligned(mpc)) begin failures++; $display("FAIL stall_req_addr c%0d got=%h exp=%h", i, if_req_addr, aligned(mpc)); end
      if (if_stall_req !== 1'b1) begin failures++; $display("FAIL stall_req c%0d got=%b exp=1", i, if_stall_req); end
      @(posedge clk); #1;
    end
    if_req_ready = 1'b0;
    if_resp_valid = 1'b1; if_resp_data = mem_word(aligned(mpc));
    @(posedge clk); #1;
    if_resp_valid = 1'b0;
    @(negedge clk);
    e = exp_inst(mpc, 0);
    checks++;
    if (if_inst_o !== e) begin failures++; $display("FAIL stall_inst got=%h exp=%h", if_inst_o, e); end
  endtask

  task automatic test_control_redirect();
    logic [63:0] a, old;
    logic [31:0] e;
    advance(0, '0, 0, '0);
    old = mpc;
    pc_stall = NEXT; control_transfer_i = 1'b1; control_target_pc_i = 64'h8000_0100;
    serve(1, 2, 0, a);
    @(negedge clk);
    e = exp_inst(old, 0);
    checks += 3;
    if (a !== aligned(old)) begin failures++; $display("FAIL redir_wait_addr got=%h exp=%h", a, aligned(old)); end
    if (if_pc_o !== old) begin failures++; $display("FAIL redir_pc_held got=%h exp=%h", if_pc_o, old); end
    if (if_inst_o !== e) begin failures++; $display("FAIL redir_inst got=%h exp=%h", if_inst_o, e); end
    @(posedge clk); #1;
    pc_stall = KEEP; control_transfer_i = 1'b0;
    mpc = 64'h8000_0100;
    serve(0, 0, 0, a);
    @(negedge clk);
    checks += 2;
    if (a !== 64'h8000_0100) begin failures++; $display("FAIL redir_addr got=%h exp=%h", a, 64'h8000_0100); end
    if (if_pc_o !== 64'h8000_0100) begin failures++; $display("FAIL redir_pc got=%h exp=%h", if_pc_o, 64'h8000_0100); end
  endtask

  task automatic test_priority_wrap();
    logic [63:0] a;
    advance(1, 64'h8000_0200, 1, 64'h8000_0300);
    serve(0, 0, 0, a);
    @(negedge clk);
    checks += 2;
    if (a !== 64'h8000_0300) begin failures++; $display("FAIL prio_addr got=%h exp=%h", a, 64'h8000_0300); end
    if (if_pc_o !== 64'h8000_0300) begin failures++; $display("FAIL prio_pc got=%h exp=%h", if_pc_o, 64'h8000_0300); end
    advance(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, '0);
    serve(0, 0, 0, a);
    advance(0, '0, 0, '0);
    serve(0, 0, 0, a);
    @(negedge clk);
    checks += 2;
    if (a !== 64'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", a); end
    if (if_inst_o !== exp_inst(64'h0, 0)) begin failures++; $display("FAIL wrap_inst got=%h exp=%h", if_inst_o, exp_inst(64'h0, 0)); end
  endtask

  task automatic test_misalign();
    logic [63:0] a;
    advance(1, 64'h8000_0102, 0, '0);
    @(negedge clk);
    checks++;
    if (if_req_valid !== 1'b0) begin failures++; $display("FAIL mis_req_valid got=%b exp=0", if_req_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks += 6;
    if (if_misalign_o !== 1'b1) begin failures++; $display("FAIL mis_flag got=%b exp=1", if_misalign_o); end
    if (if_inst_o !== NOP) begin failures++; $display("FAIL mis_inst got=%h exp=%h", if_inst_o, NOP); end
    if (if_stall_req !== 1'b0) begin failures++; $display("FAIL mis_stall got=%b exp=0", if_stall_req); end
    if (if_inst_valid_o !== 1'b0) begin failures++; $display("FAIL mis_inst_valid got=%b exp=0", if_inst_valid_o); end
    if (if_req_valid !== 1'b0) begin failures++; $display("FAIL mis_req_valid2 got=%b exp=0", if_req_valid); end
    if (if_pc_o !== 64'h8000_0102) begin failures++; $display("FAIL mis_pc got=%h exp=%h", if_pc_o, 64'h8000_0102); end
    advance(1, 64'h8000_0400, 0, '0);
    @(negedge clk);
    checks++;
    if (if_misalign_o !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b exp=0", if_misalign_o); end
    @(posedge clk); #1;
    serve(0, 0, 0, a);
  endtask

  task automatic test_reset_wait();
    logic [63:0] a;
    advance(0, '0, 0, '0);
    if_req_ready = 1'b1;
    @(posedge clk); #1;
    if_req_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (if_stall_req !== 1'b1) begin failures++; $display("FAIL rw_wait_stall got=%b exp=1", if_stall_req); end
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    checks += 2;
    if (if_pc_o !== RST_PC) begin failures++; $display("FAIL rw_pc got=%h exp=%h", if_pc_o, RST_PC); end
    if (if_inst_o !== NOP) begin failures++; $display("FAIL rw_inst got=%h exp=%h", if_inst_o, NOP); end
    rst = 1'b0;
    if_resp_valid = 1'b1; if_resp_data = {$urandom, $urandom};
    @(negedge clk);
    checks++;
    if (if_req_valid !== 1'b0) begin failures++; $display("FAIL rw_idle_req got=%b exp=0", if_req_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks += 2;
    if (if_req_valid !== 1'b1) begin failures++; $display("FAIL rw_req_valid got=%b exp=1", if_req_valid); end
    if (if_req_addr !== RST_PC) begin failures++; $display("FAIL rw_req_addr got=%h exp=%h", if_req_addr, RST_PC); end
    @(posedge clk); #1;
    if_resp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (if_req_valid !== 1'b1 || if_stall_req !== 1'b1) begin failures++; $display("FAIL rw_stale_resp got=%b%b exp=11", if_req_valid, if_stall_req); end
    @(posedge clk); #1;
    mpc = RST_PC;
    serve(0, 0, 0, a);
    @(negedge clk);
    checks++;
    if (if_inst_o !== exp_inst(mpc, 0)) begin failures++; $display("FAIL rw_inst_after got=%h exp=%h", if_inst_o, exp_inst(mpc, 0)); end
  endtask

  task automatic test_fault();
    logic [63:0] a;
    advance(0, '0, 0, '0);
    serve(0, 1, 1, a);
    @(negedge clk);
    checks += 4;
    if (if_access_fault_o !== 1'b1) begin failures++; $display("FAIL flt_flag got=%b exp=1", if_access_fault_o); end
    if (if_inst_valid_o !== 1'b0) begin failures++; $display("FAIL flt_inst_valid got=%b exp=0", if_inst_valid_o); end
    if (if_inst_o !== NOP) begin failures++; $display("FAIL flt_inst got=%h exp=%h", if_inst_o, NOP); end
    if (if_stall_req !== 1'b0) begin failures++; $display("FAIL flt_stall got=%b exp=0", if_stall_req); end
    advance(0, '0, 0, '0);
    @(negedge clk);
    checks++;
    if (if_access_fault_o !== 1'b0) begin failures++; $display("FAIL flt_clear got=%b exp=0", if_access_fault_o); end
    @(posedge clk); #1;
    serve(0, 0, 0, a);
    @(negedge clk);
    checks++;
    if (if_inst_valid_o !== 1'b1) begin failures++; $display("FAIL flt_next_valid got=%b exp=1", if_inst_valid_o); end
  endtask

  task automatic test_random();
    logic [63:0] a, ct, et;
    logic [31:0] last;
    bit ctl, exc, err;
    int unsigned r;
    last = if_inst_o;
    for (int unsigned it = 0; it < 60; it++) begin
      repeat ($urandom_range(0, 2)) begin
        pc_stall = 2'($urandom_range(1, 3));
        control_transfer_i = 1'($urandom); exception_transfer_i = 1'($urandom);
        control_target_pc_i = {$urandom, $urandom}; exception_target_pc_i = {$urandom, $urandom};
        @(posedge clk); #1;
        pc_stall = KEEP; control_transfer_i = 1'b0; exception_transfer_i = 1'b0;
        @(negedge clk);
        checks += 2;
        if (if_pc_o !== mpc) begin failures++; $display("FAIL rnd_hold_pc it%0d got=%h exp=%h", it, if_pc_o, mpc); end
        if (if_inst_o !== last) begin failures++; $display("FAIL rnd_hold_inst it%0d got=%h exp=%h", it, if_inst_o, last); end
      end
      r = $urandom_range(0, 9);
      ctl = (r < 3) || (r == 5);
      exc = (r == 3) || (r == 4) || (r == 5);
      ct = 64'h8000_0000 | 64'($urandom_range(0, 1023) << 2);
      et = 64'h8000_0000 | 64'($urandom_range(0, 1023) << 2);
      if ($urandom_range(0, 7) == 0) ct[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) et[1:0] = 2'($urandom_range(1, 3));
      advance(ctl, ct, exc, et);
      if (mpc[1:0] != 2'b00) begin
        @(posedge clk); #1;
        @(negedge clk);
        last = NOP;
        checks += 3;
        if (if_misalign_o !== 1'b1) begin failures++; $display("FAIL rnd_mis it%0d got=%b exp=1", it, if_misalign_o); end
        if (if_inst_o !== NOP) begin failures++; $display("FAIL rnd_mis_inst it%0d got=%h exp=%h", it, if_inst_o, NOP); end
        if (if_pc_o !== mpc) begin failures++; $display("FAIL rnd_mis_pc it%0d got=%h exp=%h", it, if_pc_o, mpc); end
      end else begin
        err = ($urandom_range(0, 5) == 0);
        serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), err, a);
        @(negedge clk);
        last = exp_inst(mpc, err);
        checks += 5;
        if (a !== aligned(mpc)) begin failures++; $display("FAIL rnd_addr it%0d got=%h exp=%h", it, a, aligned(mpc)); end
        if (if_pc_o !== mpc) begin failures++; $display("FAIL rnd_pc it%0d got=%h exp=%h", it, if_pc_o, mpc); end
        if (if_inst_o !== last) begin failures++; $display("FAIL rnd_inst it%0d got=%h exp=%h", it, if_inst_o, last); end
        if (if_inst_valid_o !== !err) begin failures++; $display("FAIL rnd_valid it%0d got=%b exp=%b", it, if_inst_valid_o, !err); end
        if (if_access_fault_o !== err) begin failures++; $display("FAIL rnd_fault it%0d got=%b exp=%b", it, if_access_fault_o, err); end
      end
    end
  endtask

  initial begin
    salt = $urandom;
    rst = 1'b1; pc_stall = KEEP;
    control_transfer_i = 1'b0; control_target_pc_i = '0;
    exception_transfer_i = 1'b0; exception_target_pc_i = '0;
    if_req_ready = 1'b0; if_resp_valid = 1'b0; if_resp_data = '0; if_resp_err = 1'b0;
    mpc = RST_PC;
    test_reset();
    test_sequential();
    test_ready_stall();
    test_control_redirect();
    test_priority_wrap();
    test_misalign();
    test_reset_wait();
    test_fault();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that owns the PC and raises `if_stall_req` to the hazard unit.
- Obeys the hazard unit's `pc_stall` control and its control/exception redirects.
- Fetches 32-bit instructions over a valid/ready request channel with an in-order response channel, and presents the PC/instruction pair to the IF/ID pipeline register.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first PC fetched after reset.
- NOP_INST, 32'h0000_0013, instruction presented when no valid fetch data exists.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- pc_stall  in  2  STALL_NEXT=2'b00 advance PC; STALL_KEEP=2'b01 hold; STALL_ZERO=2'b10 and 2'b11 treated as hold.
- control_transfer_i  in  1  branch/jump redirect request.
- control_target_pc_i  in  64  branch/jump target.
- exception_transfer_i  in  1  trap/return redirect request.
- exception_target_pc_i  in  64  trap target.
- if_stall_req  out  1  high while the current PC's instruction is not yet available.
- if_req_valid  out  1  fetch request valid.
- if_req_addr  out  64  fetch address, 8-byte aligned ({pc[63:3],3'b000}).
- if_req_ready  in  1  responder accepts the request.
- if_resp_valid  in  1  response data valid (one per accepted request, in order).
- if_resp_data  in  64  doubleword containing the instruction.
- if_resp_err  in  1  bus error on this response.
- if_pc_o  out  64  PC of the presented instruction.
- if_inst_o  out  32  presented instruction.
- if_inst_valid_o  out  1  if_inst_o holds real fetched data.
- if_misalign_o  out  1  if_pc_o[1:0] != 0; no fetch was issued.
- if_access_fault_o  out  1  the response carried if_resp_err.

Behaviour:
- States are IDLE, REQ, WAIT and DONE.
- Reset (asynchronous):
  - state=IDLE, pc=RESET_PC, instruction buffer=NOP_INST, fault flags 0.
  - Resulting outputs: if_req_valid=0, if_stall_req=1, if_inst_valid_o=0, if_inst_o=NOP_INST.
- IDLE: moves to REQ on the first clock after reset is released.
- REQ:
  - Entry: if pc[1:0]!=0, go straight to DONE with if_misalign_o=1, buffer=NOP_INST, and no bus request.
  - Otherwise if_req_valid=1 and if_req_addr is derived from pc.
  - Valid and address stay stable until if_req_ready. On the valid&ready cycle, go to WAIT.
- WAIT:
  - if_req_valid=0.
  - On if_resp_valid, capture if_resp_data[63:32] when pc[2]=1, else [31:0]. Also capture if_access_fault_o=if_resp_err.
  - On error the buffer is NOP_INST. Then go to DONE.
- DONE:
  - if_stall_req=0, if_inst_valid_o=1 (0 on misalign or fault).
  - If pc_stall is not STALL_NEXT: hold pc and the buffer.
  - If pc_stall is STALL_NEXT: pc <= next_pc, clear fault flags, state <= REQ.
- next_pc priority: exception_transfer_i ? exception_target_pc_i : control_transfer_i ? control_target_pc_i : pc+4 (64-bit wrap).
- Redirects outside DONE are ignored; the hazard unit holds them until if_stall_req falls.
- if_stall_req is combinational: (state != DONE).
- if_inst_o=NOP_INST whenever state != DONE.
- pc is never modified outside DONE and rst.
- if_resp_valid outside WAIT is ignored, which covers stale responses after reset.
- Minimum latency from PC update to DONE is 2 cycles: REQ with ready=1, then a response the following cycle.
- Reset asserted mid-WAIT drops the outstanding request; the responder is reset by the same rst.
- Simultaneous control and exception redirect: exception wins.

Test Plan:
- Reset, then ready=1 and a response 1 cycle after each accept:
  - First request addr=0x80000000; if_inst_o equals data[31:0].
  - pc_stall=NEXT: second request addr=0x80000000 (pc=0x80000004); if_inst_o equals data[63:32].
- Hold if_req_ready=0 for 3 cycles in REQ → if_req_valid and if_req_addr stable for 4 cycles, if_stall_req=1 throughout, accept on cycle 4.
- control_transfer_i=1 with target 0x80000100 during WAIT, repeated in DONE with pc_stall=NEXT → next request addr=0x80000100; pc+4 is not used.
- Both redirects in DONE with NEXT, control target 0x80000200, exception target 0x80000300 → pc=0x80000300.
- Redirect to 0x80000102 → no if_req_valid, if_misalign_o=1, if_inst_o=0x00000013, if_stall_req=0 one cycle after the PC update.
- rst pulsed during WAIT, then a late if_resp_valid → ignored; state IDLE then REQ, addr=0x80000000.
- if_resp_err=1 → if_access_fault_o=1, if_inst_valid_o=0, if_inst_o=NOP; flag clears on the next STALL_NEXT.
